clk_req_ctrl: RTL
=================

CLK_REQ_CTRL -- requirements
Module: clk_req_ctrl

Interface
REQ-001 SHALL have parameter HOLDOFF_CYCLES, default 4: idle cycles after bus drain before gating; legal range 0..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: cycles clock runs before wake is acknowledged; legal range 1..255.
REQ-003 SHALL have port g_clk  input  1  free-running clock; the only clock.
REQ-004 SHALL have port g_resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sleep_req  input  1  core requests sleep (WFI retired); level, held until wake_ack.
REQ-006 SHALL have port bus_busy  input  1  memory transactions outstanding.
REQ-007 SHALL have port wake_evt  input  1  interrupt pending or other wake event; level.
REQ-008 SHALL have port dbg_halt  input  1  debug request; forces clock on.
REQ-009 SHALL have port clk_req  output  1  clock request to downstream clock gate; registered.
REQ-010 SHALL have port sleeping  output  1  high in SLEEP and WAKE states; registered.
REQ-011 SHALL have port wake_ack  output  1  single-cycle pulse when clock resumed and core may proceed; registered.

Function
REQ-012 SHALL implement an FSM with states RUN, DRAIN, HOLDOFF, SLEEP and WAKE.
REQ-013 SHALL drive all outputs from flops only, with no combinational path from inputs to outputs, so clk_req is glitch-free.
REQ-014 SHALL, in RUN, go to DRAIN when sleep_req=1 and wake_evt=0 and dbg_halt=0; otherwise stay in RUN.
REQ-015 SHALL, in DRAIN, return to RUN on wake_evt or dbg_halt (abort, no wake_ack); otherwise stay while bus_busy=1.
REQ-016 SHALL, in DRAIN with bus_busy=0 and no abort, go to HOLDOFF with the counter loaded to HOLDOFF_CYCLES-1, or go directly to SLEEP if HOLDOFF_CYCLES=0.
REQ-017 SHALL, in HOLDOFF, return to RUN on wake_evt, dbg_halt, bus_busy or sleep_req=0 (abort, no wake_ack); otherwise decrement the counter and go to SLEEP when the counter is 0.
REQ-018 SHALL deassert clk_req in the first SLEEP cycle and hold clk_req=0 throughout SLEEP.
REQ-019 SHALL, in SLEEP, go to WAKE when wake_evt=1 or dbg_halt=1, loading the counter to WAKE_CYCLES-1 and asserting clk_req in the first WAKE cycle.
REQ-020 SHALL, in WAKE, decrement the counter each cycle, ignore all inputs, and go to RUN when the counter is 0.
REQ-021 SHALL assert wake_ack for exactly the first RUN cycle after WAKE, and at no other time.
REQ-022 SHALL hold sleeping=1 exactly while in SLEEP or WAKE.
REQ-023 SHALL hold clk_req=1 in every state except SLEEP.
REQ-024 SHALL size the counter at 8 bits, decrementing only and never wrapping below 0.
REQ-025 SHALL give abort priority in DRAIN and HOLDOFF: when wake_evt or dbg_halt coincides with the progress condition, the FSM returns to RUN.
REQ-026 SHALL treat sleep_req=1 and wake_evt=1 in the same RUN cycle as a no-op (stay in RUN).
REQ-027 SHALL, from RUN, reach SLEEP no sooner than 2+HOLDOFF_CYCLES cycles after sleep_req rises (RUN->DRAIN->HOLDOFF...).
REQ-028 SHALL, in SLEEP, assert wake_ack exactly 1+WAKE_CYCLES cycles after the wake_evt sampling edge.

Reset
REQ-029 SHALL, while g_resetn=0, immediately and asynchronously force: state RUN, counter 0, clk_req=1, sleeping=0, wake_ack=0.
REQ-030 SHALL, on reset assertion in any state including SLEEP, restore clk_req=1 without waiting for g_clk.
REQ-031 SHALL resume normal operation on the first g_clk rising edge after g_resetn deasserts, with no wake_ack pulse.

Verification
REQ-032 SHALL cover basic sleep: HOLDOFF=4, WAKE=2, bus_busy=0, sleep_req rises at cycle 0 -> clk_req falls at cycle 6; wake_evt at cycle 10 -> clk_req=1 at 11, wake_ack pulse at 13, sleeping low at 13.
REQ-033 SHALL cover drain: sleep_req with bus_busy=1 for 5 cycles -> FSM stays in DRAIN and clk_req=1 throughout; HOLDOFF starts the cycle after bus_busy falls.
REQ-034 SHALL cover abort: wake_evt pulses during HOLDOFF with count=2 -> return to RUN next cycle, clk_req never drops, no wake_ack.
REQ-035 SHALL cover zero holdoff: HOLDOFF=0, sleep_req with bus idle -> clk_req=0 two cycles after sleep_req rises.
REQ-036 SHALL cover debug wake: dbg_halt=1 while in SLEEP -> WAKE entered; wake_evt toggling during WAKE has no effect; single wake_ack pulse.
REQ-037 SHALL cover async reset: g_resetn=0 mid-SLEEP with g_clk stopped -> clk_req=1 and sleeping=0 immediately; no wake_ack after release.

Source files
------------

// File: rtl/clk_req_ctrl.sv
// Core clock-request controller: drains the bus, waits a holdoff, gates the clock,
// and on a wake/debug event runs the clock for a settle period before acknowledging.
module clk_req_ctrl #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int WAKE_CYCLES    = 2
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic sleep_req,
  input  logic bus_busy,
  input  logic wake_evt,
  input  logic dbg_halt,
  output logic clk_req,
  output logic sleeping,
  output logic wake_ack
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_DRAIN   = 3'd1,
    S_HOLDOFF = 3'd2,
    S_SLEEP   = 3'd3,
    S_WAKE    = 3'd4
  } state_e;

  localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);
  localparam logic       HOLD_SKIP = (HOLDOFF_CYCLES == 0);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk_req_q, clk_req_d;
  logic       sleeping_q, sleeping_d;
  logic       wake_ack_q, wake_ack_d;
  logic       abort_s;

  assign abort_s = wake_evt | dbg_halt;

  // State, counter and output flops; reset forces the clock back on without a clock edge
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= S_RUN;
      cnt_q      <= 8'd0;
      clk_req_q  <= 1'b1;
      sleeping_q <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_req_q  <= clk_req_d;
      sleeping_q <= sleeping_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  // Next-state and counter logic; aborts take priority over forward progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (sleep_req && !abort_s) state_d = S_DRAIN;
        else                       state_d = S_RUN;
      end
      S_DRAIN: begin
        if (abort_s) begin
          state_d = S_RUN;
        end else if (bus_busy) begin
          state_d = S_DRAIN;
        end else if (HOLD_SKIP) begin
          state_d = S_SLEEP;
        end else begin
          state_d = S_HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLDOFF: begin
        if (abort_s || bus_busy || !sleep_req) begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = S_SLEEP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SLEEP: begin
        if (abort_s) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end else begin
          state_d = S_SLEEP;
        end
      end
      S_WAKE: begin
        if (cnt_q == 8'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops present them in the state's first cycle
  always_comb begin
    clk_req_d  = (state_d != S_SLEEP);
    sleeping_d = (state_d == S_SLEEP) || (state_d == S_WAKE);
    wake_ack_d = (state_q == S_WAKE) && (state_d == S_RUN);
  end

  assign clk_req  = clk_req_q;
  assign sleeping = sleeping_q;
  assign wake_ack = wake_ack_q;

endmodule
